// File: rtl/strobe_mon_pkg.sv
// Shared types and constants for the strobe period monitor.
// State encoding, error counter width, default parameters and the
// saturating increment used by the mismatch counter.
package strobe_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam int ERR_W          = 8;

  localparam int DEF_WIDTH      = 14;
  localparam int DEF_EXPECTED   = 10000;
  localparam int DEF_TOLERANCE  = 0;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT    = 16000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERR_W'(1);
    end
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for the monitored strobe.
// Optional build macro: STROBE_MONITOR_SYNC_EN -- when defined, STROBE first
// passes through a two-flop synchronizer so it may be asynchronous to CLK;
// this adds two cycles of latency but leaves edge spacing unchanged.
module strobe_edge_detect
  import strobe_mon_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic STROBE,
  output logic EDGE
);

  logic strobe_s;
  logic strobe_q;

`ifdef STROBE_MONITOR_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer bringing STROBE into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= STROBE;
      sync2_q <= sync1_q;
    end
  end

  assign strobe_s = sync2_q;
`else
  assign strobe_s = STROBE;
`endif

  // Previous strobe level, so a held-high strobe yields only one edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_s;
    end
  end

  assign EDGE = strobe_s & ~strobe_q;

endmodule

// File: rtl/strobe_period_monitor.sv
// Strobe period monitor: measures edge-to-edge spacing of STROBE, compares it
// with EXPECTED +/- TOLERANCE, tracks lock, counts mismatches and flags loss
// of strobe. Optional build macro STROBE_MONITOR_SYNC_EN (see
// strobe_edge_detect) adds an input synchronizer.
module strobe_period_monitor
  import strobe_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EXPECTED   = DEF_EXPECTED,
  parameter int TOLERANCE  = DEF_TOLERANCE,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STROBE,
  output logic [WIDTH-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             MATCH,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             TIMEOUT_P
);

  localparam int                WP1     = WIDTH + 1;
  localparam logic [WIDTH:0]    EXP_C   = WP1'(EXPECTED);
  localparam logic [WIDTH:0]    TOL_C   = WP1'(TOLERANCE);
  localparam logic [WIDTH-1:0]  TO_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [3:0]        LOCK_C  = 4'(LOCK_COUNT);

  logic             edge_s;
  logic [WIDTH:0]   meas_s;
  logic [WIDTH:0]   diff_s;
  logic             match_s;

  mon_state_e       state_q,     state_d;
  logic [WIDTH-1:0] cnt_q,       cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] period_q,    period_d;
  logic             pvalid_q,    pvalid_d;
  logic             match_q,     match_d;
  logic             locked_q,    locked_d;
  logic [ERR_W-1:0] err_q,       err_d;
  logic             tmo_q,       tmo_d;

  strobe_edge_detect u_edge (
    .CLK    (CLK),
    .RESET  (RESET),
    .STROBE (STROBE),
    .EDGE   (edge_s)
  );

  // The period ending on this cycle's edge is cnt+1; widen by one bit so the
  // absolute difference never overflows.
  assign meas_s = {1'b0, cnt_q} + WP1'(1);

  // Absolute distance between the measured and nominal period.
  always_comb begin
    diff_s = '0;
    if (meas_s >= EXP_C) begin
      diff_s = meas_s - EXP_C;
    end else begin
      diff_s = EXP_C - meas_s;
    end
  end

  assign match_s = (diff_s <= TOL_C);

  // Next-state and output logic: edge measurement, lock tracking, timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + WIDTH'(1);
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    pvalid_d    = 1'b0;
    match_d     = match_q;
    locked_d    = locked_q;
    err_d       = err_q;
    tmo_d       = 1'b0;
    case (state_q)
      strobe_mon_pkg::SEARCH: begin
        // Counter parked at zero until the first edge starts a measurement.
        cnt_d       = '0;
        locked_d    = 1'b0;
        match_cnt_d = '0;
        if (edge_s) begin
          state_d = strobe_mon_pkg::MEASURE;
        end else begin
          state_d = strobe_mon_pkg::SEARCH;
        end
      end
      strobe_mon_pkg::MEASURE, strobe_mon_pkg::LOCKED: begin
        if (edge_s) begin
          // An edge always wins over a coincident timeout.
          cnt_d    = '0;
          period_d = meas_s[WIDTH-1:0];
          pvalid_d = 1'b1;
          match_d  = match_s;
          if (match_s) begin
            if (state_q == strobe_mon_pkg::LOCKED) begin
              state_d  = strobe_mon_pkg::LOCKED;
              locked_d = 1'b1;
            end else if ((match_cnt_q + 4'd1) >= LOCK_C) begin
              state_d     = strobe_mon_pkg::LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = LOCK_C;
            end else begin
              state_d     = strobe_mon_pkg::MEASURE;
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            state_d     = strobe_mon_pkg::MEASURE;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            err_d       = sat_inc(err_q);
          end
        end else if (cnt_q == TO_LAST) begin
          // Strobe lost: drop lock and hunt for a fresh first edge.
          state_d     = strobe_mon_pkg::SEARCH;
          cnt_d       = '0;
          tmo_d       = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = strobe_mon_pkg::SEARCH;
        cnt_d       = '0;
        locked_d    = 1'b0;
        match_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= strobe_mon_pkg::SEARCH;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      period_q    <= '0;
      pvalid_q    <= 1'b0;
      match_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      pvalid_q    <= pvalid_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = pvalid_q;
  assign MATCH        = match_q;
  assign LOCKED       = locked_q;
  assign ERR_COUNT    = err_q;
  assign TIMEOUT_P    = tmo_q;

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Directed testbench for strobe_period_monitor. Two instances: A with
// TOLERANCE=0, B with TOLERANCE=1; both EXPECTED=100, LOCK_COUNT=4,
// TIMEOUT=200. Honors STROBE_MONITOR_SYNC_EN for the expected latency.
module tb_strobe_period_monitor;

`ifdef STROBE_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int          cyc;
    logic [13:0] per;
    logic        m;
    logic        lk;
    logic [7:0]  err;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_a, stb_b;
  logic [13:0] per_a, per_b;
  logic        pv_a, pv_b, m_a, m_b, lk_a, lk_b, to_a, to_b;
  logic [7:0]  err_a, err_b;

  ev_t pva_q[$];
  ev_t pvb_q[$];
  ev_t toa_q[$];
  int  edge_q[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  strobe_period_monitor #(.WIDTH(14), .EXPECTED(100), .TOLERANCE(0), .LOCK_COUNT(4), .TIMEOUT(200)) u_a (
    .CLK(clk), .RESET(rst), .STROBE(stb_a), .PERIOD(per_a), .PERIOD_VALID(pv_a),
    .MATCH(m_a), .LOCKED(lk_a), .ERR_COUNT(err_a), .TIMEOUT_P(to_a)
  );

  strobe_period_monitor #(.WIDTH(14), .EXPECTED(100), .TOLERANCE(1), .LOCK_COUNT(4), .TIMEOUT(200)) u_b (
    .CLK(clk), .RESET(rst), .STROBE(stb_b), .PERIOD(per_b), .PERIOD_VALID(pv_b),
    .MATCH(m_b), .LOCKED(lk_b), .ERR_COUNT(err_b), .TIMEOUT_P(to_b)
  );

  // Cycle index of the most recent rising clock edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every PERIOD_VALID and TIMEOUT_P pulse, sampled mid-cycle.
  always @(negedge clk) begin : mon
    ev_t ev;
    if (pv_a === 1'b1) begin
      ev.cyc = cyc; ev.per = per_a; ev.m = m_a; ev.lk = lk_a; ev.err = err_a;
      pva_q.push_back(ev);
    end
    if (to_a === 1'b1) begin
      ev.cyc = cyc; ev.per = per_a; ev.m = m_a; ev.lk = lk_a; ev.err = err_a;
      toa_q.push_back(ev);
    end
    if (pv_b === 1'b1) begin
      ev.cyc = cyc; ev.per = per_b; ev.m = m_b; ev.lk = lk_b; ev.err = err_b;
      pvb_q.push_back(ev);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pva_q.delete(); pvb_q.delete(); toa_q.delete(); edge_q.delete();
  endtask

  // One rising edge on the selected strobe, high for 'high' cycles, next edge 'gap' cycles later.
  task automatic run_period(input int sel, input int gap, input int high);
    edge_q.push_back(cyc + 1);
    if (sel == 0) stb_a = 1'b1; else stb_b = 1'b1;
    for (int i = 0; i < gap; i++) begin
      if (i == high) begin stb_a = 1'b0; stb_b = 1'b0; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stb_a = 1'b0; stb_b = 1'b0;
    repeat (3) tick();
    tests++; if (per_a !== 14'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", per_a); end
    tests++; if (pv_a !== 1'b0)   begin fails++; $display("FAIL reset_pvalid: got %b expected 0", pv_a); end
    tests++; if (m_a !== 1'b0)    begin fails++; $display("FAIL reset_match: got %b expected 0", m_a); end
    tests++; if (lk_a !== 1'b0)   begin fails++; $display("FAIL reset_locked: got %b expected 0", lk_a); end
    tests++; if (err_a !== 8'd0)  begin fails++; $display("FAIL reset_err: got %0d expected 0", err_a); end
    tests++; if (to_a !== 1'b0)   begin fails++; $display("FAIL reset_timeout: got %b expected 0", to_a); end
    tests++; if (per_b !== 14'd0 || lk_b !== 1'b0) begin fails++; $display("FAIL reset_b: got period %0d locked %b expected 0 0", per_b, lk_b); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    logic exp_lk;
    clear_q();
    repeat (6) run_period(0, 100, 1);
    tests++; if (pva_q.size() !== 5) begin fails++; $display("FAIL lock_count: got %0d expected 5", pva_q.size()); end
    for (int j = 0; j < pva_q.size() && j < 5; j++) begin
      exp_lk = (j >= 3);
      tests++; if (pva_q[j].per !== 14'd100) begin fails++; $display("FAIL lock_per[%0d]: got %0d expected 100", j, pva_q[j].per); end
      tests++; if (pva_q[j].m !== 1'b1) begin fails++; $display("FAIL lock_match[%0d]: got %b expected 1", j, pva_q[j].m); end
      tests++; if (pva_q[j].lk !== exp_lk) begin fails++; $display("FAIL lock_locked[%0d]: got %b expected %b", j, pva_q[j].lk, exp_lk); end
      tests++; if (pva_q[j].err !== 8'd0) begin fails++; $display("FAIL lock_err[%0d]: got %0d expected 0", j, pva_q[j].err); end
      tests++; if (pva_q[j].cyc !== edge_q[j+1] + LAT) begin fails++; $display("FAIL lock_latency[%0d]: got cycle %0d expected %0d", j, pva_q[j].cyc, edge_q[j+1] + LAT); end
    end
    tests++; if (lk_a !== 1'b1) begin fails++; $display("FAIL lock_hold: got %b expected 1", lk_a); end
  endtask

  task automatic test_mismatch();
    int   exp_per[6] = '{100, 101, 100, 100, 100, 100};
    logic exp_m[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_lk[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   exp_err[6] = '{0, 1, 1, 1, 1, 1};
    clear_q();
    run_period(0, 101, 1);
    repeat (5) run_period(0, 100, 1);
    tests++; if (pva_q.size() !== 6) begin fails++; $display("FAIL mis_count: got %0d expected 6", pva_q.size()); end
    for (int j = 0; j < pva_q.size() && j < 6; j++) begin
      tests++;
      if (pva_q[j].per !== 14'(exp_per[j]) || pva_q[j].m !== exp_m[j] || pva_q[j].lk !== exp_lk[j] || pva_q[j].err !== 8'(exp_err[j])) begin
        fails++;
        $display("FAIL mis_entry[%0d]: got per %0d match %b locked %b err %0d expected per %0d match %b locked %b err %0d",
                 j, pva_q[j].per, pva_q[j].m, pva_q[j].lk, pva_q[j].err, exp_per[j], exp_m[j], exp_lk[j], exp_err[j]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_q();
    run_period(0, 100, 1);
    repeat (150) tick();
    tests++; if (toa_q.size() !== 1 || pva_q.size() !== 1) begin fails++; $display("FAIL to_count: got timeouts %0d valids %0d expected 1 1", toa_q.size(), pva_q.size()); end
    if (toa_q.size() == 1 && pva_q.size() == 1) begin
      tests++; if (toa_q[0].cyc - pva_q[0].cyc !== 200) begin fails++; $display("FAIL to_distance: got %0d expected 200", toa_q[0].cyc - pva_q[0].cyc); end
      tests++; if (toa_q[0].lk !== 1'b0) begin fails++; $display("FAIL to_locked: got %b expected 0", toa_q[0].lk); end
      tests++; if (toa_q[0].per !== 14'd100 || toa_q[0].err !== 8'd1) begin fails++; $display("FAIL to_keep: got per %0d err %0d expected 100 1", toa_q[0].per, toa_q[0].err); end
    end
    tests++; if (lk_a !== 1'b0) begin fails++; $display("FAIL to_unlock: got %b expected 0", lk_a); end
    clear_q();
    run_period(0, 100, 1);
    run_period(0, 100, 1);
    tests++; if (pva_q.size() !== 1) begin fails++; $display("FAIL to_relearn_count: got %0d expected 1", pva_q.size()); end
    if (pva_q.size() == 1) begin
      tests++; if (pva_q[0].per !== 14'd100 || pva_q[0].cyc !== edge_q[1] + LAT) begin fails++; $display("FAIL to_relearn: got per %0d cycle %0d expected 100 %0d", pva_q[0].per, pva_q[0].cyc, edge_q[1] + LAT); end
    end
  endtask

  task automatic test_held_and_reset();
    logic exp_lk[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_q();
    repeat (4) run_period(0, 100, 50);
    tests++; if (pva_q.size() !== 4) begin fails++; $display("FAIL held_count: got %0d expected 4", pva_q.size()); end
    for (int j = 0; j < pva_q.size() && j < 4; j++) begin
      tests++;
      if (pva_q[j].per !== 14'd100 || pva_q[j].m !== 1'b1 || pva_q[j].lk !== exp_lk[j]) begin
        fails++;
        $display("FAIL held_entry[%0d]: got per %0d match %b locked %b expected 100 1 %b", j, pva_q[j].per, pva_q[j].m, pva_q[j].lk, exp_lk[j]);
      end
    end
    repeat (30) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (per_a !== 14'd0 || pv_a !== 1'b0 || m_a !== 1'b0 || lk_a !== 1'b0 || err_a !== 8'd0 || to_a !== 1'b0) begin
      fails++;
      $display("FAIL midreset: got per %0d pv %b match %b locked %b err %0d to %b expected all 0", per_a, pv_a, m_a, lk_a, err_a, to_a);
    end
    rst = 1'b0;
    clear_q();
    run_period(0, 100, 1);
    run_period(0, 100, 1);
    tests++; if (pva_q.size() !== 1) begin fails++; $display("FAIL postreset_count: got %0d expected 1", pva_q.size()); end
    if (pva_q.size() == 1) begin
      tests++; if (pva_q[0].per !== 14'd100 || pva_q[0].err !== 8'd0 || pva_q[0].cyc !== edge_q[1] + LAT) begin fails++; $display("FAIL postreset: got per %0d err %0d cycle %0d expected 100 0 %0d", pva_q[0].per, pva_q[0].err, pva_q[0].cyc, edge_q[1] + LAT); end
    end
  endtask

  task automatic test_tolerance();
    int   gaps[6]    = '{99, 101, 99, 101, 99, 101};
    int   exp_per[5] = '{99, 101, 99, 101, 99};
    logic exp_lk[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_q();
    for (int i = 0; i < 6; i++) run_period(1, gaps[i], 1);
    tests++; if (pvb_q.size() !== 5) begin fails++; $display("FAIL tol_count: got %0d expected 5", pvb_q.size()); end
    for (int j = 0; j < pvb_q.size() && j < 5; j++) begin
      tests++;
      if (pvb_q[j].per !== 14'(exp_per[j]) || pvb_q[j].m !== 1'b1 || pvb_q[j].lk !== exp_lk[j] || pvb_q[j].err !== 8'd0) begin
        fails++;
        $display("FAIL tol_entry[%0d]: got per %0d match %b locked %b err %0d expected %0d 1 %b 0", j, pvb_q[j].per, pvb_q[j].m, pvb_q[j].lk, pvb_q[j].err, exp_per[j], exp_lk[j]);
      end
    end
  endtask

  task automatic test_err_saturation();
    clear_q();
    for (int i = 0; i <= 300; i++) begin
      run_period(0, 50, 1);
      if (i == 200 || i == 255 || i == 300) begin
        tests++;
        if (err_a !== 8'((i > 255) ? 255 : i)) begin fails++; $display("FAIL err_sat_%0d: got %0d expected %0d", i, err_a, (i > 255) ? 255 : i); end
      end
    end
    tests++; if (pva_q.size() !== 300) begin fails++; $display("FAIL err_sat_count: got %0d expected 300", pva_q.size()); end
    if (pva_q.size() > 0) begin
      tests++; if (pva_q[0].per !== 14'd50 || pva_q[0].m !== 1'b0) begin fails++; $display("FAIL err_sat_first: got per %0d match %b expected 50 0", pva_q[0].per, pva_q[0].m); end
    end
  endtask

  task automatic test_edge_at_timeout();
    clear_q();
    run_period(0, 200, 1);
    run_period(0, 10, 1);
    run_period(0, 10, 1);
    tests++; if (toa_q.size() !== 0) begin fails++; $display("FAIL edge_vs_to_pulse: got %0d timeouts expected 0", toa_q.size()); end
    tests++; if (pva_q.size() !== 3) begin fails++; $display("FAIL edge_vs_to_count: got %0d expected 3", pva_q.size()); end
    if (pva_q.size() == 3) begin
      tests++; if (pva_q[1].per !== 14'd200 || pva_q[1].m !== 1'b0 || pva_q[1].err !== 8'd255) begin fails++; $display("FAIL edge_vs_to: got per %0d match %b err %0d expected 200 0 255", pva_q[1].per, pva_q[1].m, pva_q[1].err); end
    end
  endtask

  initial begin
    rst = 1'b1; stb_a = 1'b0; stb_b = 1'b0;
    test_reset();
    test_lock();
    test_mismatch();
    test_timeout();
    test_held_and_reset();
    test_tolerance();
    test_err_saturation();
    test_edge_at_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/strobe_period_monitor.md
Name: strobe_period_monitor

Overview:
- Receive-side checker for the board's strobe/tick outputs, such as the mod-100 and mod-10000 counter carry pulses driven onto J2 pins.
- Detects rising edges on a single strobe input, measures the cycle count between consecutive edges, compares it against an expected period, and reports measured period, lock status, error count and timeout.
- Instantiated once per monitored strobe in bring-up and loopback builds.

Parameters:
- WIDTH, 14, bit width of cycle counter and PERIOD output.
- EXPECTED, 10000, nominal period in CLK cycles (edge to edge).
- TOLERANCE, 0, max allowed |measured - EXPECTED| for a match.
- LOCK_COUNT, 4, consecutive matches required to assert LOCKED (range 1..15).
- TIMEOUT, 16000, cycles without an edge before declaring loss; must be > EXPECTED+TOLERANCE and <= 2^WIDTH-1.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- STROBE  input  1  monitored strobe, level sampled on CLK.
- PERIOD  output  WIDTH  last measured edge-to-edge period, in cycles.
- PERIOD_VALID  output  1  one-cycle pulse when PERIOD updates.
- MATCH  output  1  result for the latest PERIOD; valid with PERIOD_VALID, held until next update.
- LOCKED  output  1  LOCK_COUNT consecutive matches seen, and no mismatch or timeout since.
- ERR_COUNT  output  8  saturating count of mismatched periods.
- TIMEOUT_P  output  1  one-cycle pulse on loss of strobe.

Behaviour:
- Reset: all outputs 0; state SEARCH; cnt=0; match_cnt=0; strobe_q=0.
- Edge detection: edge = STROBE & ~strobe_q, where strobe_q is STROBE registered.
  - STROBE held high produces a single edge.
  - A one-cycle high pulse produces one edge.
- Cycle counter cnt:
  - Loads 0 on an edge cycle.
  - Otherwise increments by 1 every cycle.
  - Never wraps, because TIMEOUT fires before wrap.
- Measured period = cnt+1, taken on the edge cycle. Example: edges at cycles n and n+100 give PERIOD=100.
- Latency: STROBE rises in cycle n (no sync) -> PERIOD, MATCH and PERIOD_VALID are registered and visible in cycle n+1.
- State SEARCH:
  - Counter is idle-cleared; no PERIOD update.
  - First edge -> MEASURE.
- State MEASURE, on edge:
  - PERIOD updates and PERIOD_VALID pulses.
  - On match: match_cnt++. When match_cnt reaches LOCK_COUNT -> LOCKED state; LOCKED=1 in the same cycle as that PERIOD_VALID.
  - On mismatch: match_cnt=0 and ERR_COUNT++.
- State LOCKED, on edge:
  - On match: stay locked.
  - On mismatch: LOCKED=0, match_cnt=0, ERR_COUNT++, -> MEASURE.
- Timeout (MEASURE or LOCKED):
  - Condition: cnt == TIMEOUT-1 and no edge this cycle.
  - Effect: TIMEOUT_P pulses, LOCKED=0, match_cnt=0, -> SEARCH. PERIOD keeps its last value; ERR_COUNT is unchanged.
- Simultaneous edge and timeout condition: the edge wins and is treated as a normal measurement.
- ERR_COUNT saturates at 255 and is cleared only by RESET.
- Match test: |(cnt+1) - EXPECTED| <= TOLERANCE, computed at WIDTH+1 bits; no signed overflow is possible.
- RESET mid-measurement: abandons the measurement; the next edge after reset is treated as the first edge in SEARCH.

Optional Feature:
- Macro: STROBE_MONITOR_SYNC_EN.
- Defined: STROBE passes through a 2-flop synchronizer (reset to 0) before strobe_q and edge detection, so STROBE may be asynchronous.
  - Adds 2 cycles latency: rise in cycle n -> PERIOD_VALID in cycle n+3.
  - Measured periods are unchanged.
- Undefined: STROBE must be synchronous to CLK; latency is as in Behaviour.

Decomposition:
- Package strobe_mon_pkg:
  - State typedef with encodings SEARCH=2'd0, MEASURE=2'd1, LOCKED=2'd2.
  - ERR_COUNT width constant (8).
  - Default parameter constants.
- Sub-module strobe_edge_detect:
  - Contains the optional synchronizer, strobe_q and the edge output.
  - Ports: CLK, RESET, STROBE, EDGE.
- The counter, compare and FSM stay in the top module.

Test Plan:
1. EXPECTED=100, LOCK_COUNT=4, one-cycle STROBE every 100 cycles:
   - First PERIOD_VALID comes on the 2nd edge with PERIOD=100, MATCH=1.
   - LOCKED rises with the 5th edge's PERIOD_VALID.
   - ERR_COUNT=0 throughout.
2. Locked at 100, one interval of 101 (TOLERANCE=0):
   - That edge gives PERIOD=101, MATCH=0, LOCKED=0, ERR_COUNT=1.
   - Relock after 4 further 100-cycle periods.
3. TOLERANCE=1, periods alternating 99/101 -> all MATCH=1, LOCKED after 4 matches.
4. EXPECTED=100, TIMEOUT=200, strobe stops after lock:
   - TIMEOUT_P pulses exactly 200 cycles after the last edge; LOCKED=0.
   - Next edge produces no PERIOD_VALID; the following edge does.
5. STROBE held high for 50 cycles every 100 -> one edge per period, PERIOD=100; RESET asserted mid-period -> all outputs 0 on the next cycle.
6. Same stimulus as 1, with and without STROBE_MONITOR_SYNC_EN -> identical PERIOD values; PERIOD_VALID delayed by exactly 2 cycles with the macro defined. Run 300 mismatches -> ERR_COUNT holds at 255.
